// File: rtl/pe_group_param.sv
// TAPS-lane signed dot-product engine with row accumulation, round/shift/saturate
// quantization, optional ReLU, and write-back valid/drain handshakes.
module pe_group_param #(
    parameter int TAPS = 5,
    parameter int DW   = 8,
    parameter int OW   = 11,
    parameter int ACCW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [TAPS*DW-1:0]   ifmap,
    input  logic [TAPS*DW-1:0]   weight,
    input  logic [3:0]           qshift,
    input  logic                 relu_en,
    output logic [OW-1:0]        out_data,
    output logic                 out_valid,
    output logic                 out_sat,
    output logic                 busy,
    output logic                 wb_done
);

    localparam int PW = 2 * DW;
    localparam int SW = PW + $clog2(TAPS);

    localparam logic signed [ACCW:0] MAX_Q = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACCW:0] MIN_Q = {{(ACCW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};
    localparam logic signed [ACCW:0] ONE_Q = {{ACCW{1'b0}}, 1'b1};

    // One extra bit of headroom so the rounding offset can never wrap.
    function automatic logic signed [ACCW:0] round_shift(
        input logic signed [ACCW-1:0] t,
        input logic [3:0]             sh
    );
        logic signed [ACCW:0] x;
        logic signed [ACCW:0] half;
        x    = (ACCW + 1)'(t);
        half = '0;
        if (sh != 4'd0) begin
            half = ONE_Q <<< (sh - 4'd1);
        end
        return (x + half) >>> sh;
    endfunction

    // Returns {saturated, clamped value}.
    function automatic logic [OW:0] saturate(input logic signed [ACCW:0] r);
        if (r > MAX_Q) begin
            return {1'b1, MAX_Q[OW-1:0]};
        end else if (r < MIN_Q) begin
            return {1'b1, MIN_Q[OW-1:0]};
        end
        return {1'b0, r[OW-1:0]};
    endfunction

    logic signed [PW-1:0]   prod_p1 [TAPS];
    logic                   vld_p1;
    logic                   last_p1;
    logic signed [SW-1:0]   sum_p2;
    logic                   vld_p2;
    logic                   last_p2;
    logic signed [ACCW-1:0] acc;
    logic                   pend;
    logic                   busy_prev;

    logic signed [SW-1:0]   sum_c;
    logic signed [ACCW-1:0] sum_ext;
    logic signed [ACCW-1:0] t_c;
    logic signed [ACCW:0]   r_c;
    logic [OW:0]            sat_c;
    logic signed [OW-1:0]   q_data;
    logic                   q_sat;
    logic                   pend_n;

    // ---- stage 1 -> stage 2 boundary: lane products feed the adder tree
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_c = sum_c + SW'(prod_p1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < TAPS; i++) begin
                prod_p1[i] <= $signed(ifmap[i*DW +: DW]) * $signed(weight[i*DW +: DW]);
            end
            sum_p2 <= sum_c;
        end
    end

    // ---- stage 3: accumulate, then quantize on the last row of a group
    assign sum_ext = ACCW'(sum_p2);
    assign t_c     = (pend ? acc : '0) + sum_ext;
    assign r_c     = round_shift(t_c, qshift);
    assign sat_c   = saturate(r_c);
    assign q_sat   = sat_c[OW];
    assign pend_n  = vld_p2 ? !last_p2 : pend;

    always_comb begin
        q_data = sat_c[OW-1:0];
        if (relu_en && q_data[OW-1]) begin
            q_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
            acc       <= '0;
            pend      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            busy      <= 1'b0;
            busy_prev <= 1'b0;
            wb_done   <= 1'b0;
        end else if (clear) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
            acc       <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            busy      <= 1'b0;
            busy_prev <= 1'b0;
            wb_done   <= 1'b0;
        end else if (en) begin
            vld_p1  <= in_valid;
            last_p1 <= in_last;
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            if (vld_p2 && last_p2) begin
                out_data  <= q_data;
                out_sat   <= q_sat;
                out_valid <= 1'b1;
                acc       <= '0;
            end else begin
                out_valid <= 1'b0;
                if (vld_p2) begin
                    acc <= t_c;
                end
            end
            pend      <= pend_n;
            // busy reflects the register contents that this very edge produces
            busy      <= in_valid | vld_p1 | pend_n;
            busy_prev <= busy;
            wb_done   <= busy_prev & !busy;
        end
    end

endmodule

// File: doc/pe_group_param.md
Name: pe_group_param

Overview:
- Parametrised successor of the fixed 5-tap processing-element group.
- Computes a TAPS-wide signed dot product of ifmap and weight vectors through a 3-stage pipeline.
- Optionally accumulates several dot products (rows/channels) into one result.
- Quantizes the result with a runtime shift, round-half-up and saturation, and optional ReLU.
- Drives the write-back stage with a valid pulse and a one-cycle drain-complete pulse.

Parameters:
- TAPS, 5, number of multiplier lanes (1..16).
- DW, 8, signed width of each ifmap/weight element.
- OW, 11, signed width of the quantized output.
- ACCW, 24, signed accumulator width. Integrator must ensure ACCW >= 2*DW + clog2(TAPS*max_rows); accumulator overflow is not detected.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  pipeline enable; 0 freezes every pipeline register.
- clear  in  1  synchronous flush of pipeline and accumulator.
- in_valid  in  1  ifmap/weight vectors valid this cycle.
- in_last  in  1  with in_valid: final row of the current accumulation group.
- ifmap  in  TAPS*DW  packed signed elements, lane i at [i*DW +: DW].
- weight  in  TAPS*DW  packed signed elements, same packing as ifmap.
- qshift  in  4  arithmetic right-shift amount for quantization (0..15).
- relu_en  in  1  clamp negative outputs to 0.
- out_data  out  OW  quantized signed result.
- out_valid  out  1  one-cycle pulse, out_data valid.
- out_sat  out  1  result was saturated; qualified by out_valid.
- busy  out  1  any pipeline stage valid, or a partial accumulation is pending.
- wb_done  out  1  one-cycle pulse when busy falls.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation): all stage valids, accumulator, first-row flag, out_data, out_valid, out_sat, busy, wb_done go to 0. The next accumulation group starts fresh.
- Priority per edge: rst > clear > en. When clear=1 and en=x, the effect equals reset except out_data holds its value. wb_done does not pulse on clear.
- en=0: all registers hold, including out_valid. A held out_valid=1 is seen by the consumer as one result only. Inputs are ignored.
- S1 (en=1): prod[i] <= signed ifmap[i] * signed weight[i], width 2*DW. v1 <= in_valid; l1 <= in_last.
- S2: sum <= sign-extended sum of all prod[i], width 2*DW+clog2(TAPS). v2 <= v1; l2 <= l1.
- S3, when v2=1:
  - t = (first ? 0 : acc) + sum, at ACCW bits.
  - If l2=0: acc <= t; first <= 0; out_valid <= 0.
  - If l2=1: r = (t + (qshift ? 2^(qshift-1) : 0)) >>> qshift.
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1], then apply ReLU if relu_en.
  - out_data <= result; out_sat <= (saturation occurred); out_valid <= 1; acc <= 0; first <= 1.
- When v2=0: out_valid <= 0; acc holds.
- Latency: out_valid rises exactly 3 enabled cycles after the in_valid&in_last sample. Throughput is one vector per cycle; there is no backpressure.
- qshift and relu_en are sampled in S3, at the cycle the last row reaches S3.
- busy = v1 | v2 | !first, registered.
- wb_done = registered (busy_prev & !busy).
- Back-to-back groups: a last row may be followed immediately by the next group's first row with no bubble, and the accumulator restarts correctly.
- in_last with no prior rows: the group has a single row.

Test Plan:
- TAPS=5, all ifmap=10, weight=20, in_last=1, qshift=7 -> sum 1000, out_data=8, out_valid pulse 3 cycles after input, out_sat=0, wb_done one cycle after busy falls.
- Three consecutive rows of the same vectors, last on row 3, qshift=7 -> single out_valid, out_data=23 ((3000+64)>>>7); no out_valid on rows 1-2.
- ifmap=127, weight=127, qshift=0 -> out_data=1023, out_sat=1. ifmap=-128, weight=127 -> out_data=-1024, out_sat=1.
- ifmap=-10, weight=20, qshift=7 -> out_data=-8 with relu_en=0; out_data=0 with relu_en=1 and out_sat=0.
- Single-row group stream with en dropped for 2 cycles mid-stream -> every output delayed by exactly 2 cycles, values unchanged, no lost or duplicated results.
- Assert rst, or separately clear, after row 2 of a 3-row group -> outputs/valids/busy return to 0. A fresh 1-row group then yields 8, with no residue from the aborted group.
